// File: rtl/lfsr_checker.sv
// lfsr_checker
//   Receive-side checker for the 8-bit configurable-tap LFSR generator
//   (right-shift, feedback into bit 7, stream taken from generator bit 0).
//   Seeds a local copy of the generator from 8 received bits, then
//   free-runs it and compares every following valid bit against it.
//   Too many mismatches inside one evaluation window drop lock and
//   restart acquisition.
//
// Parameters
//   ERR_THRESH : mismatches within one window that force loss of lock
//   WINDOW     : compared bits per error-evaluation window
//   CNT_W      : width of the saturating error counter
//
// Ports
//   in_clk          : clock, rising edge
//   in_rst          : asynchronous active-high reset
//   in_taps[7:0]    : feedback tap mask, same encoding as the generator
//   in_valid        : qualifies in_bit; block idles when low
//   in_bit          : received stream bit
//   in_clear_count  : synchronous clear of out_err_count
//   out_locked      : high while in LOCKED
//   out_error       : one-cycle pulse per mismatch
//   out_err_count   : saturating mismatch count
//
// Optional feature
//   LFSR_CHK_ZERO_GUARD_EN : when defined, an all-zero seed is rejected
//   and acquisition restarts instead of locking onto the lock-up state.
//
// States
//   ST_ACQUIRE | shifting received bits into the history to seed it
//   ST_LOCKED  | history free-runs; each valid bit compared with prediction

module lfsr_checker #(
    parameter int ERR_THRESH = 4,
    parameter int WINDOW     = 32,
    parameter int CNT_W      = 16
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic [7:0]       in_taps,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_clear_count,
    output logic             out_locked,
    output logic             out_error,
    output logic [CNT_W-1:0] out_err_count
);

    localparam int WIN_W = $clog2(WINDOW + 1);

    typedef enum logic {
        ST_ACQUIRE,
        ST_LOCKED
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         h_q, h_d;
    logic [2:0]         acq_cnt_q, acq_cnt_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [WIN_W-1:0]   win_err_q, win_err_d;
    logic               locked_q, locked_d;
    logic               error_q, error_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;

    logic               pred;
    logic               mismatch;
    logic [WIN_W-1:0]   win_cnt_inc;
    logic [WIN_W-1:0]   win_err_inc;

    // The generator never uses tap bit 7: bit 0 always feeds back.
    logic taps_unused;
    assign taps_unused = in_taps[7];

    // Generator feedback equation applied to the history: taps[6-k]
    // weights h[k+1], and h[0] always contributes.
    always_comb begin
        pred = h_q[0];
        for (int i = 0; i < 7; i++) begin
            pred = pred ^ (in_taps[i] & h_q[7-i]);
        end
    end

    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        acq_cnt_d   = acq_cnt_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        error_d     = 1'b0;
        mismatch    = 1'b0;
        win_cnt_inc = win_cnt_q + WIN_W'(1);
        win_err_inc = win_err_q + WIN_W'(1);

        if (in_valid) begin
            case (state_q)
                ST_ACQUIRE: begin
                    h_d       = {in_bit, h_q[7:1]};
                    acq_cnt_d = acq_cnt_q + 3'd1;
                    if (acq_cnt_q == 3'd7) begin
                        state_d   = ST_LOCKED;
                        win_cnt_d = '0;
                        win_err_d = '0;
`ifdef LFSR_CHK_ZERO_GUARD_EN
                        // All-zero seed is the generator lock-up state;
                        // locking on it would hide a dead line.
                        if (h_d == 8'h00) begin
                            state_d   = ST_ACQUIRE;
                            acq_cnt_d = 3'd0;
                        end
`endif
                    end
                end
                ST_LOCKED: begin
                    mismatch  = in_bit ^ pred;
                    error_d   = mismatch;
                    // Shift in the prediction so a single corrupted bit
                    // does not poison the local generator.
                    h_d       = {pred, h_q[7:1]};
                    win_cnt_d = win_cnt_inc;
                    if (mismatch) begin
                        win_err_d = win_err_inc;
                    end
                    // Loss of lock takes priority over the window rollover.
                    if (mismatch && (win_err_inc == WIN_W'(ERR_THRESH))) begin
                        state_d   = ST_ACQUIRE;
                        acq_cnt_d = 3'd0;
                    end else if (win_cnt_inc == WIN_W'(WINDOW)) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end
                end
                default: begin
                    state_d = ST_ACQUIRE;
                end
            endcase
        end
    end

    always_comb begin
        err_count_d = err_count_q;
        if (in_clear_count) begin
            err_count_d = '0;
        end else if (mismatch && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    assign locked_d = (state_d == ST_LOCKED);

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q     <= ST_ACQUIRE;
            h_q         <= 8'h00;
            acq_cnt_q   <= 3'd0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            locked_q    <= 1'b0;
            error_q     <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            acq_cnt_q   <= acq_cnt_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            locked_q    <= locked_d;
            error_q     <= error_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_locked    = locked_q;
    assign out_error     = error_q;
    assign out_err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Testbench for lfsr_checker: one instance with default parameters and a
// second with CNT_W=4, ERR_THRESH=WINDOW=32 for saturation and the
// threshold-on-last-bit-of-window case.

module tb_lfsr_checker;

    logic        clk;
    logic        rst;
    logic [7:0]  taps;

    logic        valid_a, bit_a, clr_a;
    logic        locked_a, error_a;
    logic [15:0] count_a;

    logic        valid_b, bit_b, clr_b;
    logic        locked_b, error_b;
    logic [3:0]  count_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ga;
    logic [7:0] gb;

    lfsr_checker dut_a (
        .in_clk         (clk),
        .in_rst         (rst),
        .in_taps        (taps),
        .in_valid       (valid_a),
        .in_bit         (bit_a),
        .in_clear_count (clr_a),
        .out_locked     (locked_a),
        .out_error      (error_a),
        .out_err_count  (count_a)
    );

    lfsr_checker #(.ERR_THRESH(32), .WINDOW(32), .CNT_W(4)) dut_b (
        .in_clk         (clk),
        .in_rst         (rst),
        .in_taps        (taps),
        .in_valid       (valid_b),
        .in_bit         (bit_b),
        .in_clear_count (clr_b),
        .out_locked     (locked_b),
        .out_error      (error_b),
        .out_err_count  (count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        flip;
        logic        clr;
        logic        e_locked;
        logic        e_error;
        logic [15:0] e_count;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(logic v, logic f, logic c, logic l, logic e, logic [15:0] n);
        vec_t r;
        r.valid = v; r.flip = f; r.clr = c;
        r.e_locked = l; r.e_error = e; r.e_count = n;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference generator: output is bit 0, shift right, feedback into bit 7.
    function automatic logic [7:0] gen_next(logic [7:0] g, logic [7:0] t);
        logic fb;
        fb = g[0];
        for (int i = 1; i < 8; i++) fb = fb ^ (t[7-i] & g[i]);
        return {fb, g[7:1]};
    endfunction

    task automatic step_raw_a(logic v, logic b, logic c);
        valid_a = v; bit_a = b; clr_a = c;
        @(posedge clk);
        #1;
        valid_a = 1'b0; clr_a = 1'b0;
    endtask

    task automatic step_a(logic v, logic flip, logic c);
        logic b;
        if (v) begin
            b  = ga[0] ^ flip;
            ga = gen_next(ga, taps);
        end else begin
            b = 1'($urandom_range(0, 1));
        end
        step_raw_a(v, b, c);
    endtask

    task automatic step_b(logic v, logic flip, logic c);
        valid_b = v; bit_b = gb[0] ^ flip; clr_b = c;
        if (v) gb = gen_next(gb, taps);
        @(posedge clk);
        #1;
        valid_b = 1'b0; clr_b = 1'b0;
    endtask

    task automatic run_good(int n);
        for (int i = 0; i < n; i++) begin
            step_a(1'b1, 1'b0, 1'b0);
            check("good_error", 32'(error_a), 32'd0);
            check("good_locked", 32'(locked_a), 32'd1);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; taps = 8'h8E;
        valid_a = 1'b0; bit_a = 1'b0; clr_a = 1'b0;
        valid_b = 1'b0; bit_b = 1'b0; clr_b = 1'b0;
        ga = 8'hA5; gb = 8'hA5;

        // Window position entering the table: 255 bits after lock -> 31.
        tbl[0]  = mk(1, 0, 0, 1, 0, 0);   // completes window, clears it
        tbl[1]  = mk(1, 1, 0, 1, 1, 1);   // single flip
        tbl[2]  = mk(0, 0, 0, 1, 0, 1);   // idle: error drops
        tbl[3]  = mk(1, 0, 0, 1, 0, 1);
        tbl[4]  = mk(1, 1, 0, 1, 1, 2);
        tbl[5]  = mk(1, 1, 0, 1, 1, 3);   // 3 errors in this window
        tbl[6]  = mk(0, 0, 1, 1, 0, 0);   // clear count
        // 28 good bits inserted here finish the window; errors reset
        tbl[7]  = mk(1, 1, 0, 1, 1, 1);
        tbl[8]  = mk(1, 1, 0, 1, 1, 2);
        tbl[9]  = mk(0, 0, 0, 1, 0, 2);
        tbl[10] = mk(1, 0, 0, 1, 0, 2);
        tbl[11] = mk(1, 1, 0, 1, 1, 3);
        tbl[12] = mk(1, 1, 0, 0, 1, 4);   // 4th in window: lock lost
        for (int i = 13; i < 20; i++) tbl[i] = mk(1, 0, 0, 0, 0, 4);
        tbl[20] = mk(1, 0, 0, 1, 0, 4);   // 8th fresh bit: relock

        #2;
        rst = 1'b1;
        #1;
        check("rst_locked", 32'(locked_a), 32'd0);
        check("rst_error", 32'(error_a), 32'd0);
        check("rst_count", 32'(count_a), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Acquisition
        for (int i = 0; i < 8; i++) begin
            step_a(1'b1, 1'b0, 1'b0);
            if (i == 6) check("acq_locked_7", 32'(locked_a), 32'd0);
        end
        check("acq_locked_8", 32'(locked_a), 32'd1);
        check("acq_count", 32'(count_a), 32'd0);

        // 255 correct bits with random valid gaps
        begin
            int good;
            good = 0;
            while (good < 255) begin
                logic v;
                v = 1'($urandom_range(0, 1));
                step_a(v, 1'b0, 1'b0);
                if (v) good++;
                check("rand_error", 32'(error_a), 32'd0);
            end
        end
        check("rand_locked", 32'(locked_a), 32'd1);
        check("rand_count", 32'(count_a), 32'd0);

        for (int i = 0; i < 21; i++) begin
            if (i == 7) run_good(28);
            step_a(tbl[i].valid, tbl[i].flip, tbl[i].clr);
            check($sformatf("tbl%0d_locked", i), 32'(locked_a), 32'(tbl[i].e_locked));
            check($sformatf("tbl%0d_error", i), 32'(error_a), 32'(tbl[i].e_error));
            check($sformatf("tbl%0d_count", i), 32'(count_a), 32'(tbl[i].e_count));
        end
        run_good(20);
        check("relock_count", 32'(count_a), 32'd4);

        // Asynchronous reset mid-lock
        #2;
        rst = 1'b1;
        #1;
        check("arst_locked", 32'(locked_a), 32'd0);
        check("arst_count", 32'(count_a), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All-zero line
        for (int i = 0; i < 20; i++) begin
            step_raw_a(1'b1, 1'b0, 1'b0);
`ifdef LFSR_CHK_ZERO_GUARD_EN
            check("zero_locked", 32'(locked_a), 32'd0);
`else
            if (i == 6) check("zero_locked_7", 32'(locked_a), 32'd0);
            if (i >= 7) check("zero_locked", 32'(locked_a), 32'd1);
            check("zero_error", 32'(error_a), 32'd0);
`endif
        end
        check("zero_count", 32'(count_a), 32'd0);

        // Small-counter instance: saturation and threshold on window end
        do_reset;
        gb = 8'hA5;
        for (int i = 0; i < 8; i++) step_b(1'b1, 1'b0, 1'b0);
        check("b_acq_locked", 32'(locked_b), 32'd1);
        for (int i = 1; i <= 40; i++) begin
            step_b(1'b1, 1'b1, 1'b0);
            if (i == 15) check("b_count_15", 32'(count_b), 32'd15);
            if (i == 20) begin
                check("b_sat_count", 32'(count_b), 32'd15);
                check("b_sat_error", 32'(error_b), 32'd1);
                check("b_sat_locked", 32'(locked_b), 32'd1);
            end
            if (i == 31) check("b_locked_31", 32'(locked_b), 32'd1);
            if (i == 32) check("b_loss_32", 32'(locked_b), 32'd0);
            if (i == 40) begin
                check("b_relock", 32'(locked_b), 32'd1);
                check("b_count_40", 32'(count_b), 32'd15);
            end
        end
        step_b(1'b1, 1'b1, 1'b1);
        check("b_clr_count", 32'(count_b), 32'd0);
        check("b_clr_error", 32'(error_b), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
